// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller.
//   mc_state_e : controller state (idle, instruction fetch, load, store)
//   MC_IO_BASE : first address of the IO window
//   LEN_*      : load/store length codes from the load-store buffer
//   len_bytes  : length code -> byte count (the unused code 2 means a word)
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_IFETCH = 2'd1,
    MC_LOAD   = 2'd2,
    MC_STORE  = 2'd3
  } mc_state_e;

  localparam logic [31:0] MC_IO_BASE = 32'h0003_0000;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      LEN_W:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller between the instruction cache / load-store buffer and
// the byte-wide unified RAM/IO port. Word fetches and 1/2/4-byte loads and
// stores are serialised into byte transfers; read bytes are reassembled
// little-endian and completion is signalled by a one-cycle valid pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   flush               aborts an in-flight fetch/load
//   mem_din/mem_dout    RAM read / write byte
//   mem_a, mem_wr       RAM byte address, write strobe
//   io_buffer_full      IO output buffer full (stalls IO stores)
//   ic_enable/ic_addr   fetch request;  ic_valid/ic_data completion
//   ls_enable/ls_wr/ls_addr/ls_len/ls_wdata   load/store request
//   ls_valid/ls_rdata   load/store completion, load data zero-extended
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(MC_IO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              ic_enable,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [31:0]       ic_data,
  input  logic              ls_enable,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_len,
  input  logic [31:0]       ls_wdata,
  output logic              ls_valid,
  output logic [31:0]       ls_rdata
);

  mc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        issue_q, issue_d;
  logic [1:0]        recv_q, recv_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ic_valid_q, ic_valid_d;
  logic              ls_valid_q, ls_valid_d;
  logic [31:0]       ic_data_q, ic_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic        ls_io_stall;
  logic        ls_go;
  logic        ic_go;
  logic [31:0] assembled;

  // A requester is not re-accepted while its own completion pulse is up;
  // an IO store waits for buffer space without blocking fetches.
  assign ls_io_stall = ls_wr && (ls_addr >= IO_BASE) && io_buffer_full;
  assign ls_go       = ls_enable && !ls_valid_q && !ls_io_stall && !flush;
  assign ic_go       = ic_enable && !ic_valid_q && !flush && !ls_go;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n_d        = n_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    ic_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    ic_data_d  = ic_data_q;
    ls_rdata_d = ls_rdata_q;

    // Buffer with the byte arriving this cycle merged into its lane.
    assembled = buf_q;
    assembled[{recv_q, 3'b000} +: 8] = mem_din;

    case (state_q)
      MC_IDLE: begin
        if (ls_go) begin
          base_d  = ls_addr;
          n_d     = len_bytes(ls_len);
          issue_d = 3'd1;
          recv_d  = '0;
          buf_d   = '0;
          mem_a_d = ls_addr;
          if (ls_wr) begin
            state_d    = MC_STORE;
            wdata_d    = ls_wdata;
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = MC_LOAD;
          end
        end else if (ic_go) begin
          state_d = MC_IFETCH;
          base_d  = ic_addr;
          n_d     = 3'd4;
          issue_d = 3'd1;
          recv_d  = '0;
          buf_d   = '0;
          mem_a_d = ic_addr;
        end
      end

      MC_IFETCH, MC_LOAD: begin
        if (flush) begin
          state_d = MC_IDLE;
        end else begin
          // issue_q counts edges since acceptance; the byte addressed at
          // edge k arrives at edge k+2, so receiving lags issuing by two.
          issue_d = issue_q + 3'd1;
          if (issue_q < n_q) begin
            mem_a_d = base_q + ADDR_W'(issue_q);
          end
          if (issue_q >= 3'd2) begin
            buf_d  = assembled;
            recv_d = recv_q + 2'd1;
            if ({1'b0, recv_q} == n_q - 3'd1) begin
              state_d = MC_IDLE;
              if (state_q == MC_IFETCH) begin
                ic_data_d  = assembled;
                ic_valid_d = 1'b1;
              end else begin
                ls_rdata_d = assembled;
                ls_valid_d = 1'b1;
              end
            end
          end
        end
      end

      MC_STORE: begin
        // A committed store always runs to completion; flush is not honoured.
        if (issue_q < n_q) begin
          mem_a_d    = base_q + ADDR_W'(issue_q);
          mem_dout_d = wdata_q[{issue_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          issue_d    = issue_q + 3'd1;
        end else begin
          ls_valid_d = 1'b1;
          state_d    = MC_IDLE;
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      base_q     <= '0;
      n_q        <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      buf_q      <= '0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      base_q     <= base_d;
      n_q        <= n_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_valid_q <= ic_valid_d;
      ls_valid_q <= ls_valid_d;
      ic_data_q  <= ic_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;
  assign ic_valid = ic_valid_q;
  assign ic_data  = ic_data_q;
  assign ls_valid = ls_valid_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requests push expected responses into
// queues, a monitor pops them on each completion pulse. Expected data comes
// from a flat byte-array memory model updated when each request is issued.
module tb_mem_ctrl;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef struct packed {
    logic        st;
    logic [31:0] d;
  } ls_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy = 1'b1;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ic_enable;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;
  logic        ls_enable;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_len;
  logic [31:0] ls_wdata;
  logic        ls_valid;
  logic [31:0] ls_rdata;

  mem_ctrl #(.ADDR_W(32), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
    .ls_enable(ls_enable), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rdy_edges = 0;
  bit          rdy_mode = 1'b0;
  logic        rdy_manual = 1'b1;

  logic [7:0] ram [0:65535];
  logic [7:0] mdl [0:65535];
  logic [7:0] io_log [$];
  logic [31:0] exp_ic [$];
  ls_exp_t     exp_ls [$];

  // RAM: address registered by the controller, data one further cycle later.
  // The whole system freezes with rdy, so the RAM is enabled by it too.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) begin
        if (mem_a >= IO_BASE) io_log.push_back(mem_dout);
        else ram[mem_a[15:0]] <= mem_dout;
      end
    end
  end

  always @(posedge clk) begin
    if (rdy) rdy_edges++;
    #2;
    rdy = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_manual;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned k = 0; k < n; k++) v[8*k +: 8] = mdl[16'(a + k)];
    return v;
  endfunction

  // Monitor: pops one expectation per completion pulse (a pulse is consumed
  // in the rdy-high cycle it ends in) and checks it is one cycle wide.
  ls_exp_t mon_x;
  bit      ic_prev = 1'b0;
  bit      ls_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy) check("mem_wr_frozen", 32'(mem_wr), 32'd0);
      if (ic_prev) check("ic_pulse_width", 32'(ic_valid), 32'd0);
      if (ls_prev) check("ls_pulse_width", 32'(ls_valid), 32'd0);
      ic_prev = 1'b0;
      ls_prev = 1'b0;
      if (ic_valid && rdy) begin
        ic_prev = 1'b1;
        if (exp_ic.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ic_unexpected: ic_valid with ic_data %h, expected no completion", ic_data);
        end else check("ic_data", ic_data, exp_ic.pop_front());
      end
      if (ls_valid && rdy) begin
        ls_prev = 1'b1;
        if (exp_ls.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ls_unexpected: ls_valid with ls_rdata %h, expected no completion", ls_rdata);
        end else begin
          mon_x = exp_ls.pop_front();
          if (!mon_x.st) check("ls_rdata", ls_rdata, mon_x.d);
        end
      end
    end
  end

  // Issue one request and hold it until its completion pulse. skew is the
  // number of rdy-high edges the request is expected to wait before being
  // accepted (arbitration or IO stall). Latency is counted in rdy-high edges.
  task automatic run_req(input bit is_ic, input bit wr, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wd, input int unsigned skew);
    int unsigned n, lat, e0, e, t;
    logic [31:0] sh;
    n   = is_ic ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    lat = is_ic ? 6 : (wr ? n + 1 : n + 2);
    if (is_ic) exp_ic.push_back(model_read(addr, 4));
    else if (wr) begin
      exp_ls.push_back('{1'b1, 32'd0});
      if (addr < IO_BASE)
        for (int unsigned k = 0; k < n; k++) begin
          sh = wd >> (8 * k);
          mdl[16'(addr + k)] = sh[7:0];
        end
    end else exp_ls.push_back('{1'b0, model_read(addr, n)});
    if (is_ic) begin
      ic_enable = 1'b1; ic_addr = addr;
    end else begin
      ls_enable = 1'b1; ls_wr = wr; ls_addr = addr; ls_len = len; ls_wdata = wd;
    end
    e0 = rdy_edges;
    e  = 0;
    t  = 0;
    do begin
      @(posedge clk); #1;
      t++;
      e = rdy_edges - e0;
      if (e <= skew) check("mem_wr_wait", 32'(mem_wr), 32'd0);
      else if (e - skew <= n) begin
        check("mem_a", mem_a, addr + 32'(e - skew - 1));
        if (wr) begin
          sh = wd >> (8 * (e - skew - 1));
          check("mem_dout", 32'(mem_dout), 32'(sh[7:0]));
          check("mem_wr_store", 32'(mem_wr), 32'(rdy));
        end else check("mem_wr_read", 32'(mem_wr), 32'd0);
      end
    end while (!(is_ic ? ic_valid : ls_valid) && t < 300);
    if (is_ic) ic_enable = 1'b0; else ls_enable = 1'b0;
    if (t >= 300) check("completion_timeout", 32'd0, 32'd1);
    else check(is_ic ? "ic_latency" : "ls_latency", e, lat + skew);
    t = 0;
    while ((is_ic ? ic_valid : ls_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_clears", 32'(is_ic ? ic_valid : ls_valid), 32'd0);
  endtask

  logic [7:0] b;

  initial begin
    rst = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    ic_enable = 1'b0; ic_addr = '0;
    ls_enable = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
    for (int unsigned i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      mdl[i] = b;
    end
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    mdl[16'h1000] = 8'h13; mdl[16'h1001] = 8'h05; mdl[16'h1002] = 8'h00; mdl[16'h1003] = 8'h00;
    ram[16'h0020] = 8'hFF; mdl[16'h0020] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_ic_valid", 32'(ic_valid), 32'd0);
    check("rst_ls_valid", 32'(ls_valid), 32'd0);
    check("rst_ic_data", ic_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch of a known word, then load/fetch arbitration.
    run_req(1'b1, 1'b0, 32'h1000, 2'd0, 32'd0, 0);
    fork
      run_req(1'b0, 1'b0, 32'h20, 2'd0, 32'd0, 0);
      run_req(1'b1, 1'b0, 32'h1000, 2'd0, 32'd0, 3);
    join

    // Word store and readback.
    run_req(1'b0, 1'b1, 32'h40, 2'd3, 32'hDEADBEEF, 0);
    run_req(1'b0, 1'b0, 32'h40, 2'd3, 32'd0, 0);

    // IO store held off by a full output buffer for six cycles.
    io_buffer_full = 1'b1;
    fork
      run_req(1'b0, 1'b1, IO_BASE, 2'd0, 32'h5A, 6);
      begin
        repeat (6) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join

    // Fetch flushed two cycles in: no completion, then a clean fetch.
    ic_enable = 1'b1; ic_addr = 32'h1000;
    @(posedge clk); #1 ic_enable = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("flushed_fetch_silent", 32'(ic_valid), 32'd0);
    run_req(1'b1, 1'b0, 32'h2000, 2'd0, 32'd0, 0);

    // Flush during a store is ignored.
    fork
      run_req(1'b0, 1'b1, 32'h60, 2'd3, 32'h11223344, 0);
      begin
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end
    join
    run_req(1'b0, 1'b0, 32'h60, 2'd3, 32'd0, 0);

    // rdy low for three edges mid-load and three more across ls_valid.
    fork
      run_req(1'b0, 1'b0, 32'h40, 2'd3, 32'd0, 0);
      begin
        repeat (2) @(posedge clk);
        #1 rdy_manual = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_manual = 1'b1;
        repeat (4) @(posedge clk);
        #1 rdy_manual = 1'b0;
        repeat (3) begin
          @(posedge clk); #3;
          check("ls_valid_held", 32'(ls_valid), 32'd1);
        end
        rdy_manual = 1'b1;
      end
    join

    // Reset in the middle of a word store: bytes 0 and 1 reach RAM, no pulse.
    ls_enable = 1'b1; ls_wr = 1'b1; ls_addr = 32'h80; ls_len = 2'd3; ls_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1 ls_enable = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_ls_valid", 32'(ls_valid), 32'd0);
    mdl[16'h0080] = 8'hD4;
    mdl[16'h0081] = 8'hC3;
    repeat (6) @(posedge clk);
    #1;
    run_req(1'b0, 1'b0, 32'h80, 2'd3, 32'd0, 0);

    // Random mix under a random rdy pattern.
    rdy_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0:       run_req(1'b1, 1'b0, 32'h100 + $urandom_range(0, 63), 2'd0, 32'd0, 0);
        1:       run_req(1'b0, 1'b0, 32'h100 + $urandom_range(0, 63), 2'($urandom), 32'd0, 0);
        default: run_req(1'b0, 1'b1, 32'h100 + $urandom_range(0, 63), 2'($urandom), $urandom, 0);
      endcase
    end
    rdy_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check("ic_queue_drained", exp_ic.size(), 32'd0);
    check("ls_queue_drained", exp_ls.size(), 32'd0);
    check("io_write_count", io_log.size(), 32'd1);
    if (io_log.size() > 0) check("io_write_byte", 32'(io_log[0]), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
